prog_updown_counter: RTL

Parametrised up/down counter. It supersedes the fixed 8-bit enable/overflow counter and adds a programmable modulus, a synchronous load, an input prescaler, direction control, and wrap reporting. Wrap is reported three ways: a combinational terminal-count flag, a registered one-cycle wrap pulse, and a sticky flag with a saturating wrap counter. It sits in the digital timing/event-generation path, driven by a register interface or by a user state machine.

---
 rtl/prog_updown_counter.sv | 92 +++++++++
 1 files changed

// File: rtl/prog_updown_counter.sv
// Programmable-modulus up/down counter with input prescaler, synchronous load/clear,
// and wrap reporting as a combinational flag, a one-cycle pulse, a sticky flag and a saturating count.
module prog_updown_counter #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4,
    parameter int WRAPS_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      modulus,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  sticky_clr,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  wrap_pulse,
    output logic                  wrap_sticky,
    output logic [WRAPS_W-1:0]    wrap_cnt
);

    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic                  wrap_pulse_q, wrap_pulse_d;
    logic                  wrap_sticky_q, wrap_sticky_d;
    logic [WRAPS_W-1:0]    wrap_cnt_q, wrap_cnt_d;

    logic tick;
    logic at_wrap;

    // >= so that lowering prescale below the running phase ticks at once
    assign tick    = enable && (pre_q >= prescale);
    // Up wrap uses >= so a loaded value above modulus folds back to 0
    assign at_wrap = up_dn ? (count_q >= modulus) : (count_q == '0);
    assign tc      = tick && !clr && !load && at_wrap;

    always_comb begin
        count_d       = count_q;
        pre_d         = pre_q;
        wrap_pulse_d  = tc;
        wrap_sticky_d = tc | (wrap_sticky_q & ~sticky_clr);
        wrap_cnt_d    = wrap_cnt_q;

        if (clr) begin
            count_d = '0;
            pre_d   = '0;
        end else if (load) begin
            count_d = load_val;
            pre_d   = '0;
        end else begin
            if (enable)
                pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                if (up_dn)
                    count_d = at_wrap ? '0 : count_q + 1'b1;
                else
                    count_d = at_wrap ? modulus : count_q - 1'b1;
            end
        end

        // A wrap on the same edge as sticky_clr leaves exactly one wrap recorded
        if (sticky_clr)
            wrap_cnt_d = {{(WRAPS_W-1){1'b0}}, tc};
        else if (tc && !(&wrap_cnt_q))
            wrap_cnt_d = wrap_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q       <= '0;
            pre_q         <= '0;
            wrap_pulse_q  <= 1'b0;
            wrap_sticky_q <= 1'b0;
            wrap_cnt_q    <= '0;
        end else begin
            count_q       <= count_d;
            pre_q         <= pre_d;
            wrap_pulse_q  <= wrap_pulse_d;
            wrap_sticky_q <= wrap_sticky_d;
            wrap_cnt_q    <= wrap_cnt_d;
        end
    end

    assign count       = count_q;
    assign wrap_pulse  = wrap_pulse_q;
    assign wrap_sticky = wrap_sticky_q;
    assign wrap_cnt    = wrap_cnt_q;

endmodule
